// File: rtl/ppu_tile_shifter_pkg.sv
// rtl/ppu_tile_shifter_pkg.sv - shared defaults and channel indices for the PPU tile shifter
package ppu_shift_pkg;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_WIDTH       = 16;
    localparam int DEF_LOAD_WIDTH  = 8;
    localparam int DEF_OFFSET_BITS = 3;

    localparam int CH_PAT_LO = 0;
    localparam int CH_PAT_HI = 1;
    localparam int CH_ATT_LO = 2;
    localparam int CH_ATT_HI = 3;

endpackage

// File: rtl/ppu_tile_shifter_if.sv
// rtl/ppu_tile_shifter_if.sv - staging handshake between tile fetch and the shifter
interface ppu_tile_shifter_if
    import ppu_shift_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int LOAD_WIDTH = DEF_LOAD_WIDTH
);
    logic                           i_stage_valid;
    logic [CHANNELS*LOAD_WIDTH-1:0] i_stage_data;
    logic                           o_stage_ready;

    modport master (output i_stage_valid, output i_stage_data, input  o_stage_ready);
    modport slave  (input  i_stage_valid, input  i_stage_data, output o_stage_ready);
endinterface

// File: rtl/ppu_tile_shifter_channel.sv
// rtl/ppu_tile_shifter_channel.sv - one background shift register with upper reload and fine-x tap
module ppu_shift_channel
    import ppu_shift_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOAD_WIDTH  = DEF_LOAD_WIDTH,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_shift,
    input  logic                   i_reload,
    input  logic [LOAD_WIDTH-1:0]  i_load_data,
    input  logic [OFFSET_BITS-1:0] i_offset,
    output logic                   o_pixel,
    output logic [WIDTH-1:0]       o_q
);
    logic [WIDTH-1:0] q_next;

    // Reload lands on top of the already-shifted value, so a same-cycle shift still moves the low half.
    always_comb begin
        q_next = i_shift ? {1'b0, o_q[WIDTH-1:1]} : o_q;
        if (i_reload) begin
            q_next[WIDTH-1 -: LOAD_WIDTH] = i_load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_q <= '0;
        end else begin
            o_q <= q_next;
        end
    end

    assign o_pixel = o_q[i_offset];
endmodule

// File: rtl/ppu_tile_shifter.sv
// rtl/ppu_tile_shifter.sv - multi-channel background shifter with one-tile staging buffer
module ppu_tile_shifter
    import ppu_shift_pkg::*;
#(
    parameter int CHANNELS    = DEF_CHANNELS,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOAD_WIDTH  = DEF_LOAD_WIDTH,
    parameter int OFFSET_BITS = DEF_OFFSET_BITS
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    ppu_tile_shifter_if.slave         stage_if,
    input  logic                      i_shift,
    input  logic                      i_load,
    input  logic [OFFSET_BITS-1:0]    i_offset,
    output logic [CHANNELS-1:0]       o_pixel,
    output logic                      o_reload,
    output logic                      o_underrun,
    output logic [CHANNELS*WIDTH-1:0] o_debug_data
);
    logic [CHANNELS*LOAD_WIDTH-1:0] stage_q;
    logic                           stage_full;
    logic [OFFSET_BITS-1:0]         cnt;
    logic                           auto_reload;
    logic                           take;

    assign auto_reload            = i_shift && (cnt == OFFSET_BITS'(LOAD_WIDTH - 1));
    assign o_reload               = i_load || auto_reload;
    // A reload frees the slot in the same cycle, so fetch never has to wait out a full buffer.
    assign stage_if.o_stage_ready = !stage_full || o_reload;
    assign take                   = stage_if.i_stage_valid && stage_if.o_stage_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stage_q    <= '0;
            stage_full <= 1'b0;
            cnt        <= '0;
            o_underrun <= 1'b0;
        end else begin
            if (take) begin
                stage_q <= stage_if.i_stage_data;
            end
            stage_full <= take || (stage_full && !o_reload);
            if (o_reload && !stage_full) begin
                o_underrun <= 1'b1;
            end
            if (i_load) begin
                cnt <= '0;
            end else if (i_shift) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [LOAD_WIDTH-1:0] load_data;
        assign load_data = stage_full ? stage_q[c*LOAD_WIDTH +: LOAD_WIDTH] : '0;

        ppu_shift_channel #(
            .WIDTH       (WIDTH),
            .LOAD_WIDTH  (LOAD_WIDTH),
            .OFFSET_BITS (OFFSET_BITS)
        ) u_chan (
            .i_clk       (i_clk),
            .i_reset     (i_reset),
            .i_shift     (i_shift),
            .i_reload    (o_reload),
            .i_load_data (load_data),
            .i_offset    (i_offset),
            .o_pixel     (o_pixel[c]),
            .o_q         (o_debug_data[c*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_ppu_tile_shifter.sv
// tb/tb_ppu_tile_shifter.sv - randomized and directed checks of ppu_tile_shifter against a reference model
module tb_ppu_tile_shifter;
    import ppu_shift_pkg::*;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_shift;
    logic        i_load;
    logic [2:0]  i_offset;
    logic [3:0]  o_pixel;
    logic        o_reload;
    logic        o_underrun;
    logic [63:0] o_debug_data;

    ppu_tile_shifter_if #(.CHANNELS(4), .LOAD_WIDTH(8)) stage_if ();

    ppu_tile_shifter dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .stage_if     (stage_if),
        .i_shift      (i_shift),
        .i_load       (i_load),
        .i_offset     (i_offset),
        .o_pixel      (o_pixel),
        .o_reload     (o_reload),
        .o_underrun   (o_underrun),
        .o_debug_data (o_debug_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each channel register is an integer, a shift halves it, a reload replaces the top byte.
    int m_reg   [4];
    int m_stage [4];
    bit m_full;
    int m_cnt;
    bit m_under;

    logic       last_reload;
    logic [3:0] last_pixel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_debug();
        logic [63:0] v = '0;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(m_reg[c]);
        return v;
    endfunction

    function automatic logic [3:0] model_pixel(input int off);
        logic [3:0] v;
        for (int c = 0; c < 4; c++) v[c] = 1'((m_reg[c] >> off) & 1);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_reg[c]   = 0;
            m_stage[c] = 0;
        end
        m_full  = 0;
        m_cnt   = 0;
        m_under = 0;
    endtask

    task automatic idle_inputs();
        i_reset                = 1'b0;
        i_shift                = 1'b0;
        i_load                 = 1'b0;
        stage_if.i_stage_valid = 1'b0;
        stage_if.i_stage_data  = '0;
    endtask

    task automatic step(input bit rst, input bit ld, input bit sh, input bit vl,
                        input logic [31:0] d, input logic [2:0] off);
        bit exp_reload, exp_ready, take;
        @(negedge clk);
        i_reset = rst; i_load = ld; i_shift = sh; i_offset = off;
        stage_if.i_stage_valid = vl; stage_if.i_stage_data = d;
        #1;
        exp_reload = ld || (sh && m_cnt == 7);
        exp_ready  = !m_full || exp_reload;
        check("reload",   64'(o_reload), 64'(exp_reload));
        check("ready",    64'(stage_if.o_stage_ready), 64'(exp_ready));
        check("underrun", 64'(o_underrun), 64'(m_under));
        check("debug",    o_debug_data, model_debug());
        check("pixel",    64'(o_pixel), 64'(model_pixel(int'(off))));
        last_reload = o_reload;
        last_pixel  = o_pixel;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            take = vl && exp_ready;
            for (int c = 0; c < 4; c++) begin
                if (sh) m_reg[c] = m_reg[c] / 2;
                if (exp_reload) m_reg[c] = (m_reg[c] % 256) + (m_full ? m_stage[c] : 0) * 256;
            end
            if (exp_reload && !m_full) m_under = 1;
            if (exp_reload) m_full = 0;
            if (take) begin
                m_full = 1;
                for (int c = 0; c < 4; c++) m_stage[c] = int'(d[c*8 +: 8]);
            end
            if (ld) m_cnt = 0;
            else if (sh) m_cnt = (m_cnt + 1) % 8;
        end
        #1;
        idle_inputs();
    endtask

    initial begin
        logic [7:0] a5 = 8'hA5;
        idle_inputs();
        i_offset = '0;
        i_reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_debug",    o_debug_data, 64'h0);
        check("rst_ready",    64'(stage_if.o_stage_ready), 64'h1);
        check("rst_reload",   64'(o_reload), 64'h0);
        check("rst_underrun", 64'(o_underrun), 64'h0);
        check("rst_pixel",    64'(o_pixel), 64'h0);
        i_reset = 1'b0;

        // Load with shift low: upper byte takes the tile, lower byte holds.
        step(0, 0, 0, 1, 32'hA5A5A5A5, 3'd0);
        step(0, 1, 0, 0, 32'h0, 3'd0);
        check("load_debug",    o_debug_data, 64'hA500A500A500A500);
        check("load_empty",    64'(stage_if.o_stage_ready), 64'h1);
        check("load_underrun", 64'(o_underrun), 64'h0);

        // Eight shifts: reload on the eighth, tile 3C lands above the shifted A5.
        step(0, 0, 0, 1, 32'h3C3C3C3C, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 32'h0, 3'd0);
            check("auto_reload_pulse", 64'(last_reload), 64'(i == 7));
        end
        check("auto_debug", o_debug_data, 64'h3CA53CA53CA53CA5);

        // Drain A5 through the fine-x tap; the next reload finds staging empty.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 32'h0, 3'd0);
            check("pixel_seq", 64'(last_pixel), 64'({4{a5[i]}}));
        end
        check("underrun_set",   64'(o_underrun), 64'h1);
        check("underrun_debug", o_debug_data, 64'h003C003C003C003C);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h0, 3'(i));
        check("underrun_sticky", 64'(o_underrun), 64'h1);

        // Stage full while fetch keeps offering; the reload cycle accepts the new tile.
        step(0, 0, 0, 1, 32'h11111111, 3'd3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 32'h22222222, 3'd1);
        check("refill_full", 64'(stage_if.o_stage_ready), 64'h0);

        // Load together with shift at cnt=5 restarts the period.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'h0, 3'd2);
        step(0, 1, 1, 0, 32'h0, 3'd2);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, 32'h0, 3'd4);
            check("restart_pulse", 64'(last_reload), 64'(i == 7));
        end

        // Mid-stream reset drops the staged tile and the tile offered during reset.
        step(0, 0, 0, 1, 32'h55555555, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h0, 3'd0);
        step(1, 0, 1, 1, 32'h77777777, 3'd0);
        check("mid_rst_debug",    o_debug_data, 64'h0);
        check("mid_rst_ready",    64'(stage_if.o_stage_ready), 64'h1);
        check("mid_rst_underrun", 64'(o_underrun), 64'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 32'h0, 3'd0);
        check("mid_rst_dropped", o_debug_data, 64'h0);
        check("mid_rst_under2",  64'(o_underrun), 64'h1);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0),
                 32'($urandom),
                 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
